// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-generation stage: format codes, RV32/64 base opcodes
// and the XLEN legality check.
package imm_pkg;

    typedef enum logic [2:0] {
        FmtR    = 3'd0,
        FmtI    = 3'd1,
        FmtS    = 3'd2,
        FmtB    = 3'd3,
        FmtU    = 3'd4,
        FmtJ    = 3'd5,
        FmtNone = 3'd7
    } imm_fmt_e;

    localparam logic [6:0] OpcLoad    = 7'b0000011;
    localparam logic [6:0] OpcOpImm   = 7'b0010011;
    localparam logic [6:0] OpcOpImm32 = 7'b0011011;
    localparam logic [6:0] OpcJalr    = 7'b1100111;
    localparam logic [6:0] OpcSystem  = 7'b1110011;
    localparam logic [6:0] OpcStore   = 7'b0100011;
    localparam logic [6:0] OpcBranch  = 7'b1100011;
    localparam logic [6:0] OpcLui     = 7'b0110111;
    localparam logic [6:0] OpcAuipc   = 7'b0010111;
    localparam logic [6:0] OpcJal     = 7'b1101111;
    localparam logic [6:0] OpcOp      = 7'b0110011;
    localparam logic [6:0] OpcOp32    = 7'b0111011;

    function automatic bit xlen_legal(input int unsigned xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational RISC-V immediate decoder: opcode -> format code, illegal flag and the
// sign-extended XLEN-bit immediate.
module imm_extract
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [31:0]     instruction,
    output logic [2:0]      fmt,
    output logic            illegal,
    output logic [XLEN-1:0] imm
);

    imm_fmt_e    fmt_dec;
    logic [31:0] raw;

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("imm_extract: XLEN must be 32 or 64");
    end

    always_comb begin
        fmt_dec = FmtNone;
        illegal = 1'b0;
        case (instruction[6:0])
            OpcLoad, OpcOpImm, OpcOpImm32, OpcJalr, OpcSystem: fmt_dec = FmtI;
            OpcStore:                                          fmt_dec = FmtS;
            OpcBranch:                                         fmt_dec = FmtB;
            OpcLui, OpcAuipc:                                  fmt_dec = FmtU;
            OpcJal:                                            fmt_dec = FmtJ;
            OpcOp, OpcOp32:                                    fmt_dec = FmtR;
            default: begin
                fmt_dec = FmtNone;
                illegal = 1'b1;
            end
        endcase
    end

    // Each format is already sign-extended to 32 bits here; widening to XLEN happens below.
    always_comb begin
        raw = '0;
        case (fmt_dec)
            FmtI: raw = {{20{instruction[31]}}, instruction[31:20]};
            FmtS: raw = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            FmtB: raw = {{19{instruction[31]}}, instruction[31], instruction[7],
                         instruction[30:25], instruction[11:8], 1'b0};
            FmtU: raw = {instruction[31:12], 12'b0};
            FmtJ: raw = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                         instruction[20], instruction[30:21], 1'b0};
            default: raw = '0;
        endcase
    end

    assign fmt = fmt_dec;

    if (XLEN == 32) begin : g_imm32
        assign imm = raw;
    end else begin : g_imm_ext
        assign imm = {{(XLEN-32){raw[31]}}, raw};
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Single registered pipeline stage around imm_extract: valid/ready handshake, flush,
// synchronous reset and a saturating count of accepted illegal opcodes.
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instruction,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_data,
    output logic [2:0]       imm_fmt,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    logic [2:0]      dec_fmt;
    logic            dec_illegal;
    logic [XLEN-1:0] dec_imm;

    logic             valid_q, valid_d;
    logic [XLEN-1:0]  imm_q, imm_d;
    logic [2:0]       fmt_q, fmt_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             xfer;

    imm_extract #(
        .XLEN(XLEN)
    ) u_extract (
        .instruction(instruction),
        .fmt        (dec_fmt),
        .illegal    (dec_illegal),
        .imm        (dec_imm)
    );

    // The reset term keeps the stage visibly ready while the held entry is being dropped.
    assign in_ready = reset || !valid_q || out_ready;
    assign xfer     = in_valid && in_ready;

    always_comb begin
        valid_d   = valid_q;
        imm_d     = imm_q;
        fmt_d     = fmt_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (xfer) begin
            valid_d   = 1'b1;
            imm_d     = dec_imm;
            fmt_d     = dec_fmt;
            illegal_d = dec_illegal;
            if (dec_illegal && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            imm_q     <= '0;
            fmt_q     <= FmtNone;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            imm_q     <= imm_d;
            fmt_q     <= fmt_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_valid   = valid_q;
    assign imm_data    = imm_q;
    assign imm_fmt     = fmt_q;
    assign illegal     = illegal_q;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: vector table through a scoreboard on the XLEN=64 instance, plus
// hand sequences on an XLEN=32 instance and a CNT_W=2 instance.
module tb_imm_gen_stage;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    localparam int NV = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Main instance, XLEN=64, CNT_W=16
    logic        rst, flush, in_valid, out_ready, in_ready, out_valid, ill;
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [15:0] cnt;

    imm_gen_stage #(.XLEN(64), .CNT_W(16)) u_dut (
        .clk(clk), .reset(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instr), .out_valid(out_valid), .out_ready(out_ready),
        .imm_data(imm), .imm_fmt(fmt), .illegal(ill), .illegal_cnt(cnt)
    );

    // XLEN=32 instance
    logic        rst_b, flush_b, in_valid_b, out_ready_b, in_ready_b, out_valid_b, ill_b;
    logic [31:0] instr_b, imm_b;
    logic [2:0]  fmt_b;
    logic [15:0] cnt_b;

    imm_gen_stage #(.XLEN(32), .CNT_W(16)) u_dut32 (
        .clk(clk), .reset(rst_b), .flush(flush_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .instruction(instr_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .imm_data(imm_b), .imm_fmt(fmt_b), .illegal(ill_b),
        .illegal_cnt(cnt_b)
    );

    // CNT_W=2 instance for saturation
    logic        rst_c, flush_c, in_valid_c, out_ready_c, in_ready_c, out_valid_c, ill_c;
    logic [31:0] instr_c;
    logic [63:0] imm_c;
    logic [2:0]  fmt_c;
    logic [1:0]  cnt_c;

    imm_gen_stage #(.XLEN(64), .CNT_W(2)) u_dutsat (
        .clk(clk), .reset(rst_c), .flush(flush_c), .in_valid(in_valid_c),
        .in_ready(in_ready_c), .instruction(instr_c), .out_valid(out_valid_c),
        .out_ready(out_ready_c), .imm_data(imm_c), .imm_fmt(fmt_c), .illegal(ill_c),
        .illegal_cnt(cnt_c)
    );

    vec_t        tbl[NV];
    vec_t        sb[$];
    vec_t        cur;
    int unsigned exp_cnt = 0;
    logic        took;
    logic [15:0] saved_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        cur   = v;
        instr = v.instr;
    endtask

    // One clock of the main instance: compare at the negedge against the scoreboard, then
    // update the model with whatever the handshake accepts on the coming posedge.
    task automatic step(output logic accepted);
        logic exp_rdy;
        @(negedge clk);
        exp_rdy = rst || (sb.size() == 0) || out_ready;
        check("in_ready", in_ready, exp_rdy);
        if (!rst) begin
            check("out_valid", out_valid, sb.size() != 0);
            check("illegal_cnt", cnt, exp_cnt);
            if (sb.size() != 0) begin
                check("imm_data", imm, sb[0].imm);
                check("imm_fmt", fmt, sb[0].fmt);
                check("illegal", ill, sb[0].ill);
                if (out_ready) void'(sb.pop_front());
            end
        end
        accepted = 1'b0;
        if (rst) begin
            sb.delete();
            exp_cnt = 0;
        end else if (flush) begin
            sb.delete();
        end else if (in_valid && exp_rdy) begin
            sb.push_back(cur);
            accepted = 1'b1;
            if (cur.ill && exp_cnt != 32'hFFFF) exp_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0};
        tbl[1]  = '{32'h00112623, 64'h0000_0000_0000_000C, 3'd2, 1'b0};
        tbl[2]  = '{32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0};
        tbl[3]  = '{32'h800002B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0};
        tbl[4]  = '{32'h001000EF, 64'h0000_0000_0000_0800, 3'd5, 1'b0};
        tbl[5]  = '{32'h00000033, 64'h0,                   3'd0, 1'b0};
        tbl[6]  = '{32'h0000007F, 64'h0,                   3'd7, 1'b1};
        tbl[7]  = '{32'hFFFFFFF3, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0};
        tbl[8]  = '{32'h80000067, 64'hFFFF_FFFF_FFFF_F800, 3'd1, 1'b0};
        tbl[9]  = '{32'hFFFFF017, 64'hFFFF_FFFF_FFFF_F000, 3'd4, 1'b0};
        tbl[10] = '{32'h8000003B, 64'h0,                   3'd0, 1'b0};
        tbl[11] = '{32'h7FF00003, 64'h0000_0000_0000_07FF, 3'd1, 1'b0};
        tbl[12] = '{32'h00000057, 64'h0,                   3'd7, 1'b1};
        tbl[13] = '{32'h0000001B, 64'h0,                   3'd1, 1'b0};
        tbl[14] = '{32'hFFFFFFFF, 64'h0,                   3'd7, 1'b1};
        tbl[15] = '{32'hFE112E23, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
        rst_b = 1'b1; flush_b = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b0; instr_b = '0;
        rst_c = 1'b1; flush_c = 1'b0; in_valid_c = 1'b0; out_ready_c = 1'b0; instr_c = '0;
        cur = tbl[0];

        // Reset state
        step(took);
        step(took);
        rst = 1'b0;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_imm_data", imm, 64'h0);
        check("rst_imm_fmt", fmt, 3'd7);
        check("rst_illegal", ill, 1'b0);
        check("rst_illegal_cnt", cnt, 16'h0);
        check("rst_in_ready", in_ready, 1'b1);

        // Streaming the whole table, consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            drive(tbl[i]);
            in_valid = 1'b1;
            step(took);
            check("stream_accept", took, 1'b1);
        end
        in_valid = 1'b0;
        step(took);
        step(took);
        check("stream_drained", sb.size(), 0);

        // Backpressure: held entry stable for 3 cycles, then back-to-back with no bubble
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(tbl[1]);
        step(took);
        drive(tbl[2]);
        for (int i = 0; i < 3; i++) begin
            step(took);
            check("bp_no_accept", took, 1'b0);
        end
        out_ready = 1'b1;
        for (int k = 2; k <= 6; k++) begin
            drive(tbl[k]);
            step(took);
            check("bp_stream_accept", took, 1'b1);
        end
        in_valid = 1'b0;
        step(took);
        step(took);
        check("bp_drained", sb.size(), 0);

        // Flush with a held entry and a concurrent illegal transfer
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(tbl[0]);
        step(took);
        saved_cnt = cnt;
        out_ready = 1'b1;
        drive(tbl[6]);
        flush = 1'b1;
        step(took);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_cnt_held", cnt, saved_cnt);
        step(took);

        // Reset mid-operation drops the held entry without a handshake
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(tbl[3]);
        step(took);
        rst = 1'b1;
        step(took);
        rst      = 1'b0;
        in_valid = 1'b0;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_imm_fmt", fmt, 3'd7);
        check("midrst_cnt", cnt, 16'h0);
        step(took);

        // XLEN=32 instance
        @(posedge clk); #1;
        rst_b = 1'b0;
        out_ready_b = 1'b1;
        instr_b = 32'hFFF00093; in_valid_b = 1'b1;
        @(posedge clk); #1;
        in_valid_b = 1'b0;
        check("x32_i_valid", out_valid_b, 1'b1);
        check("x32_i_imm", imm_b, 32'hFFFF_FFFF);
        check("x32_i_fmt", fmt_b, 3'd1);
        instr_b = 32'h001000EF; in_valid_b = 1'b1;
        @(posedge clk); #1;
        in_valid_b = 1'b0;
        check("x32_j_imm", imm_b, 32'h0000_0800);
        check("x32_j_fmt", fmt_b, 3'd5);
        instr_b = 32'h800002B7; in_valid_b = 1'b1;
        @(posedge clk); #1;
        in_valid_b = 1'b0;
        check("x32_u_imm", imm_b, 32'h8000_0000);
        check("x32_u_fmt", fmt_b, 3'd4);
        @(posedge clk); #1;
        check("x32_drain", out_valid_b, 1'b0);

        // CNT_W=2: counter saturates at 3, reset clears it
        rst_c = 1'b0;
        out_ready_c = 1'b1;
        instr_c = 32'h0000007F;
        in_valid_c = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            check("sat_cnt", cnt_c, (k < 3) ? k : 3);
        end
        out_ready_c = 1'b0;
        #1;
        check("sat_bp_in_ready", in_ready_c, 1'b0);
        rst_c = 1'b1;
        #1;
        check("sat_rst_in_ready", in_ready_c, 1'b1);
        @(posedge clk); #1;
        rst_c = 1'b0;
        check("sat_rst_cnt", cnt_c, 2'd0);
        check("sat_rst_out_valid", out_valid_c, 1'b0);
        check("sat_post_rst_in_ready", in_ready_c, 1'b1);
        in_valid_c = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/imm_gen_stage.md
IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, meaning the immediate output width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the illegal-opcode counter.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port flush, input, 1 bit: discard the held entry.
REQ-007 The block SHALL have port in_valid, input, 1 bit: instruction present.
REQ-008 The block SHALL have port in_ready, output, 1 bit: stage can accept.
REQ-009 The block SHALL have port instruction, input, 32 bits: raw RV instruction.
REQ-010 The block SHALL have port out_valid, output, 1 bit: registered result valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: consumer accepts.
REQ-012 The block SHALL have port imm_data, output, XLEN bits: sign-extended immediate.
REQ-013 The block SHALL have port imm_fmt, output, 3 bits: format code (R=0, I=1, S=2, B=3, U=4, J=5, NONE=7).
REQ-014 The block SHALL have port illegal, output, 1 bit: opcode not recognised.
REQ-015 The block SHALL have port illegal_cnt, output, CNT_W bits: count of illegal opcodes accepted.

Function
REQ-016 Format SHALL be decoded from instruction[6:0] as follows: I for 0000011, 0010011, 0011011, 1100111, 1110011; S for 0100011; B for 1100011; U for 0110111, 0010111; J for 1101111; R for 0110011, 0111011; all other opcodes are NONE with illegal=1.
REQ-017 The immediate for each format SHALL be:
- I = inst[31:20];
- S = {inst[31:25], inst[11:7]};
- B = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
- U = {inst[31:12], 12'b0};
- J = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
REQ-018 Every immediate SHALL be sign-extended from inst[31] to XLEN, and for R and NONE formats imm_data SHALL be 0.
REQ-019 The stage SHALL be a single registered stage with latency exactly 1 cycle: an input accepted on edge N appears on the outputs after edge N.
REQ-020 A transfer SHALL occur when in_valid && in_ready, and in_ready SHALL equal !out_valid || out_ready (combinational, with no dependency on in_valid).
REQ-021 When out_valid=1 && out_ready=0, imm_data, imm_fmt and illegal SHALL hold stable.
REQ-022 Simultaneous output handshake and input transfer SHALL replace the held entry in the same cycle, with no bubble.
REQ-023 Flush SHALL clear out_valid on the next edge, take priority over any transfer in that cycle, and prevent the in-flight instruction from updating the counter.
REQ-024 illegal_cnt SHALL increment by 1 per transferred instruction with illegal=1 and saturate at all-ones without wrapping.
REQ-025 Data registers SHALL update only on a transfer, so that they are don't-care while out_valid=0.

Reset
REQ-026 On reset: out_valid=0, imm_data=0, imm_fmt=NONE, illegal=0, illegal_cnt=0.
REQ-027 Reset asserted mid-operation SHALL drop the held entry without any handshake, and reset SHALL take priority over flush and transfer.
REQ-028 in_ready SHALL be 1 during and immediately after reset.

Structure
REQ-029 Package imm_pkg SHALL hold the format-code enum, the opcode constants, and the XLEN legality check.
REQ-030 The combinational decoder SHALL be one sub-module, imm_extract (instruction in; format, illegal and XLEN immediate out).
REQ-031 imm_gen_stage SHALL contain only the handshake register, the flush/reset logic and the counter.

Verification
REQ-032 Bench scenario, I-type: input 0xFFF00093 (addi x1,x0,-1) -> imm_data 0xFFFFFFFFFFFFFFFF, fmt I, one cycle later.
REQ-033 Bench scenario, S, B and U types:
- 0x00112623 (sw) -> imm_data 12, fmt S;
- 0xFE000EE3 (beq -4) -> imm_data 0xFFFFFFFFFFFFFFFC, fmt B;
- 0x800002B7 (lui) -> imm_data 0xFFFFFFFF80000000, fmt U.
REQ-034 Bench scenario, J type and XLEN=32: 0x001000EF (jal +2048) -> imm_data 0x800, fmt J; repeating with XLEN=32 and input 0xFFF00093 -> imm_data 0xFFFFFFFF.
REQ-035 Bench scenario, backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable; release -> back-to-back transfers with no bubble and no loss.
REQ-036 Bench scenario, flush: assert flush with out_valid=1 and a concurrent transfer of 0x0000007F -> out_valid=0 next cycle and illegal_cnt unchanged.
REQ-037 Bench scenario, saturation with CNT_W=2: 5 illegal opcodes -> illegal_cnt stops at 3; then assert reset -> illegal_cnt=0 and out_valid=0.
